csa_pipe_adder: RTL
===================

# csa_pipe_adder

Pipelined, width-parametrised conditional sum adder/subtractor for the arithmetic datapath. It generalises the team's 8-bit combinational conditional sum adder to any power-of-two width, with one register rank per merge level. It adds a subtract mode, a signed-overflow flag and valid/ready flow control on both sides. It sits between operand-fetch logic and any consumer that can stall.

## Interface
Parameters:
- WIDTH, 16, operand width; power of two, 4..64.
- LEVELS, log2(WIDTH), number of conditional-sum merge levels. Derived; not overridden.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all pipeline state.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when op=1.
- op  input  1  0 = x+y+cin, 1 = x-y, computed as x+~y+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. For op=1, cout=1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage 0 (pre-compute):
  - Let yy = op ? ~y : y and c0 = op ? 1 : cin.
  - For every bit i, form the candidate pairs (s0,c0) and (s1,c1) assuming carry-in 0 and 1.
  - Bit 0 is resolved directly with c0.
  - Register all candidates, op-adjusted operands and valid.
- Merge level k (k=1..LEVELS):
  - Adjacent blocks of 2^(k-1) bits combine into blocks of 2^k.
  - The upper block's candidate sum/carry pair is selected by the lower block's carry-out for each assumption.
  - The block containing bit 0 uses the true resolved carry.
  - Register each level.
- After level LEVELS, the full-width sum and cout are resolved.
- Track the carry into the MSB alongside the data so ovf is exact.
- Arithmetic:
  - sum = (x + yy + c0) mod 2^WIDTH.
  - cout = bit WIDTH of that sum.
  - No saturation.
  - Examples at WIDTH=8: 0xFF+0x01 gives 0x00/cout=1; 0x00-0x01 gives 0xFF/cout=0.
- Flow control: one global enable, en = !out_valid | out_ready.
  - in_ready = en.
  - When en=0 every stage holds, including valid bits and data.
  - When en=1 every stage advances. Bubbles (valid=0) advance too; data of invalid beats is don't-care.
- A beat is accepted on a cycle with in_valid & in_ready. A beat is delivered on a cycle with out_valid & out_ready.
- Simultaneous accept and deliver in one cycle is legal and sustains 1 beat/cycle.
- in_ready may depend combinationally on out_ready. There is no other combinational input-to-output path.

## Timing
- Latency: L = LEVELS+1 cycles from accept edge to out_valid high, with no stall. L = 4 at WIDTH=8 and 5 at WIDTH=16.
- Throughput: 1 beat/cycle while out_ready=1.
- Stalls: out_valid held with out_ready=0 keeps sum/cout/ovf stable until the delivering edge. Capacity is L beats; nothing is dropped or duplicated.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, all internal valids 0.
  - in_ready is 1 from the cycle after reset, because out_valid=0.
- Reset mid-operation: asserting rst at any time discards all in-flight beats immediately (asynchronous). After deassertion, no stale beat emerges.
- in_valid is sampled only at rising edges. Changing x/y/op while in_valid=1 and in_ready=0 is allowed; only the value at the accepting edge is used.

## Structure
- Package csa_pkg:
  - op encoding constants OP_ADD=1'b0, OP_SUB=1'b1.
  - A struct/typedef for a candidate block {sum0, c0, sum1, c1}.
  - A log2 helper function for LEVELS.
- Sub-module csa_merge_level: one parametrised merge level (block size, WIDTH). It contains the selection muxes plus the enable-gated register rank. It is instantiated LEVELS times in a generate loop.
- The top level holds stage 0, valid shift chain, enable logic and ovf extraction.

## Test plan
- WIDTH=8, add: x=0xFF, y=0x01, cin=0, op=0 -> sum=0x00, cout=1, ovf=0, exactly 4 cycles after accept.
- WIDTH=8, signed overflow: x=0x7F, y=0x01, op=0 -> sum=0x80, cout=0, ovf=1. Also x=0x80, y=0xFF -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8, subtract: x=0x05, y=0x07, op=1, cin=1 (must be ignored) -> sum=0xFE, cout=0, ovf=0. Also x=0x07, y=0x05 -> 0x02, cout=1.
- Backpressure, WIDTH=16:
  - Stream 20 back-to-back beats with random operands.
  - Hold out_ready=0 for 7 cycles mid-stream.
  - Required: in_ready drops, outputs hold stable, all 20 results arrive in order with no loss.
- Reset mid-stream: assert rst with 3 beats in flight -> out_valid=0 and sum=0 immediately. The first output after reset corresponds to the first beat accepted after reset.
- Exhaustive self-check at WIDTH=8: all 2^17 (x,y,cin) combinations for op=0, plus all (x,y) for op=1, checked against a reference model with random out_ready.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: op encodings, per-bit candidate struct and sizing helpers for the conditional sum adder
package csa_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef struct packed {
    logic sum0;
    logic c0;
    logic sum1;
    logic c1;
  } cand_t;
  function automatic int csa_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
  function automatic int csa_coff(input int w, input int k);
    return 2 * w - 2 * (w >> k);
  endfunction
  function automatic cand_t bit_cand(input logic a, input logic b);
    return '{sum0: a ^ b, c0: a & b, sum1: ~(a ^ b), c1: a | b};
  endfunction
endpackage

// File: rtl/csa_merge_level.sv
// csa_merge_level: one conditional-sum merge rank (clk, rst, en_i; s0/s1 candidate sums, c0/c1 per-block carries in -> merged blocks of 2*BLK out, registered)
module csa_merge_level #(
  parameter int WIDTH = 16,
  parameter int BLK = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  input  logic [WIDTH-1:0]            s0_i,
  input  logic [WIDTH-1:0]            s1_i,
  input  logic [WIDTH/BLK-1:0]        c0_i,
  input  logic [WIDTH/BLK-1:0]        c1_i,
  output logic [WIDTH-1:0]            s0_o,
  output logic [WIDTH-1:0]            s1_o,
  output logic [WIDTH/(2*BLK)-1:0]    c0_o,
  output logic [WIDTH/(2*BLK)-1:0]    c1_o
);
  localparam int NB = WIDTH / (2 * BLK);
  logic [WIDTH-1:0] s0_d, s1_d, s0_q, s1_q;
  logic [NB-1:0] c0_d, c1_d, c0_q, c1_q;
  always_comb begin
    s0_d = '0;
    s1_d = '0;
    c0_d = '0;
    c1_d = '0;
    for (int j = 0; j < NB; j++) begin
      s0_d[2*j*BLK +: BLK] = s0_i[2*j*BLK +: BLK];
      s1_d[2*j*BLK +: BLK] = s1_i[2*j*BLK +: BLK];
      s0_d[(2*j+1)*BLK +: BLK] = c0_i[2*j] ? s1_i[(2*j+1)*BLK +: BLK] : s0_i[(2*j+1)*BLK +: BLK];
      s1_d[(2*j+1)*BLK +: BLK] = c1_i[2*j] ? s1_i[(2*j+1)*BLK +: BLK] : s0_i[(2*j+1)*BLK +: BLK];
      c0_d[j] = c0_i[2*j] ? c1_i[2*j+1] : c0_i[2*j+1];
      c1_d[j] = c1_i[2*j] ? c1_i[2*j+1] : c0_i[2*j+1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
    end else if (en_i) begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end
  assign s0_o = s0_q;
  assign s1_o = s1_q;
  assign c0_o = c0_q;
  assign c1_o = c1_q;
endmodule

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined conditional sum add/sub (in_valid/in_ready, x, y, cin, op in; out_valid/out_ready, sum, cout, ovf out), latency log2(WIDTH)+1
module csa_pipe_adder import csa_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = csa_log2(WIDTH);
  localparam int CW = 2 * WIDTH - 1;
  logic en, ci;
  logic [WIDTH-1:0] yy, s0_d, s1_d, c0_d, c1_d, s0_q, s1_q, c0_q, c1_q;
  logic [LEVELS:0] v_q, p_q;
  logic [(LEVELS+1)*WIDTH-1:0] s0_f, s1_f;
  logic [CW-1:0] c0_f, c1_f;
  cand_t cd;
  assign en = !v_q[LEVELS] | out_ready;
  assign in_ready = en;
  always_comb begin
    yy = (op == OP_SUB) ? ~y : y;
    ci = (op == OP_SUB) ? 1'b1 : cin;
    cd = '0;
    s0_d = '0;
    s1_d = '0;
    c0_d = '0;
    c1_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cd = bit_cand(x[i], yy[i]);
      s0_d[i] = cd.sum0;
      c0_d[i] = cd.c0;
      s1_d[i] = cd.sum1;
      c1_d[i] = cd.c1;
    end
    s0_d[0] = ci ? s1_d[0] : s0_d[0];
    c0_d[0] = ci ? c1_d[0] : c0_d[0];
    s1_d[0] = s0_d[0];
    c1_d[0] = c0_d[0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
      v_q <= '0;
      p_q <= '0;
    end else if (en) begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
      v_q <= {v_q[LEVELS-1:0], in_valid};
      p_q <= {p_q[LEVELS-1:0], x[WIDTH-1] ^ yy[WIDTH-1]};
    end
  end
  assign s0_f[WIDTH-1:0] = s0_q;
  assign s1_f[WIDTH-1:0] = s1_q;
  assign c0_f[WIDTH-1:0] = c0_q;
  assign c1_f[WIDTH-1:0] = c1_q;
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int B = 1 << (k - 1);
    csa_merge_level #(.WIDTH(WIDTH), .BLK(B)) u_merge (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .s0_i (s0_f[(k-1)*WIDTH +: WIDTH]),
      .s1_i (s1_f[(k-1)*WIDTH +: WIDTH]),
      .c0_i (c0_f[csa_coff(WIDTH, k-1) +: WIDTH/B]),
      .c1_i (c1_f[csa_coff(WIDTH, k-1) +: WIDTH/B]),
      .s0_o (s0_f[k*WIDTH +: WIDTH]),
      .s1_o (s1_f[k*WIDTH +: WIDTH]),
      .c0_o (c0_f[csa_coff(WIDTH, k) +: WIDTH/(2*B)]),
      .c1_o (c1_f[csa_coff(WIDTH, k) +: WIDTH/(2*B)])
    );
  end
  assign out_valid = v_q[LEVELS];
  assign sum = s0_f[LEVELS*WIDTH +: WIDTH];
  assign cout = c0_f[CW-1];
  assign ovf = cout ^ sum[WIDTH-1] ^ p_q[LEVELS];
  always_comb assert (s1_f[LEVELS*WIDTH +: WIDTH] == sum && c1_f[CW-1] == cout);
endmodule
